dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Sequencer and arbiter in front of the data memory. The memory is combinational, level-sensitive and single-ported, with a 32-bit word-indexed address.
- Arbitrates between two requesters: the pipeline MEM stage (cpu) and a debug/loader port (dbg).
- Converts each accepted request into exactly one single-cycle R or W strobe on the memory.
- Returns registered read data with a one-cycle valid pulse, and generates the pipeline stall.

Parameters:
- NUM_WORDS, 8, number of 32-bit words in the data memory; a word address >= NUM_WORDS is out of range.
- AW, 32, address width on all ports.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request; held with all its fields stable until cpu_rvalid.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  word address.
- cpu_wdata  in  32  write data.
- cpu_stall  out  1  combinational; equals cpu_req & ~cpu_rvalid.
- cpu_rvalid  out  1  one-cycle completion pulse (reads and writes).
- cpu_rdata  out  32  read data, valid only while cpu_rvalid is high.
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/AW/32  same semantics as the cpu_* inputs.
- dbg_rvalid  out  1  one-cycle completion pulse.
- dbg_rdata  out  32  read data, valid only while dbg_rvalid is high.
- dm_R  out  1  memory read strobe.
- dm_W  out  1  memory write strobe.
- dm_Addr  out  AW  memory word address.
- dm_W_data  out  32  memory write data.
- dm_R_data  in  32  memory read data.
- err  out  1  one-cycle pulse on an out-of-range access, coincident with the rvalid pulse.

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Every state is one cycle long; an access therefore takes 3 cycles from acceptance to rvalid.
- IDLE:
  - If any request is present, pick a winner, then latch owner, we, addr and wdata into internal registers. Next state is ACCESS.
  - With no request, stay in IDLE.
- Arbitration is round-robin.
  - With exactly one requester, it wins.
  - When both request in the same cycle, the requester not served last wins.
  - The last-served register resets to dbg, so the cpu wins the first tie.
- ACCESS:
  - dm_Addr and dm_W_data are driven from the latched registers.
  - dm_R = ~we & in_range; dm_W = we & in_range. The asserted strobe is high for exactly this cycle.
  - For reads, dm_R_data is captured into the rdata register at the clock edge that ends ACCESS.
  - Next state is RESP.
- RESP:
  - The owner's rvalid is 1 and the owner's rdata is driven from the rdata register.
  - The non-owner's rvalid is 0 and its rdata is 0.
  - last_served is updated to the owner. Next state is IDLE.
- Strobe timing:
  - dm_R and dm_W are 0 in IDLE and RESP, and are never both 1.
  - dm_Addr and dm_W_data hold their last latched values outside ACCESS. This keeps the level-sensitive memory from seeing glitching or a repeated write.
- Range check: in_range = (addr < NUM_WORDS), compared over the full AW-bit unsigned value. On an out-of-range access:
  - neither strobe is asserted;
  - rdata is 0;
  - err pulses in RESP.
  - The access otherwise completes normally, with rvalid.
- If the requester drops its request during ACCESS or RESP, the transaction still completes and rvalid still pulses; the requester ignores it. Requests are sampled only in IDLE.
- Back-to-back: a requester that holds req after its rvalid is re-arbitrated in the following IDLE cycle. Peak throughput is one access per 3 cycles.
- The rvalid, err and strobe outputs are registered (driven from FSM state and latched regs); cpu_stall is the only combinational output.
- Reset, including reset mid-operation:
  - State returns to IDLE and last_served to dbg.
  - The latched owner, we, addr, wdata and rdata registers clear to 0.
  - All outputs are 0 in the cycle after rst is sampled high. cpu_stall still follows cpu_req combinationally.
  - An in-flight access is abandoned: no rvalid pulse, and no strobe in the cycle after reset.

Decomposition:
- Shared package dm_pkg: FSM state enum (IDLE/ACCESS/RESP), owner encoding (OWN_CPU=0, OWN_DBG=1), and NUM_WORDS_DEF=8.
- One sub-module: rr_arb2. It is a 2-way round-robin grant with inputs req[1:0] and last, and output a one-hot gnt. Everything else stays flat in dm_arbiter.

Test Plan:
- CPU write, no contention:
  - Stimulus: cpu_req=1, we=1, addr=3, wdata=0xDEADBEEF.
  - Response: dm_W=1 with dm_Addr=3 for exactly one cycle (cycle 2), cpu_rvalid in cycle 3, cpu_stall high for cycles 1-2. A following read of addr 3 returns cpu_rdata=0xDEADBEEF.
- Tie, both ports reading:
  - Stimulus: right after reset, cpu reads addr 1 and dbg reads addr 2, both holding req.
  - Response: cpu is served first (rvalid in cycle 3), dbg second (rvalid in cycle 6), then cpu again; service alternates.
- Out of range:
  - Stimulus: dbg read of addr 8 with NUM_WORDS=8.
  - Response: no dm_R/dm_W pulse, dbg_rvalid=1, dbg_rdata=0, and err=1 in the same cycle.
- Reset mid-operation:
  - Stimulus: assert rst during ACCESS of a cpu write.
  - Response: dm_W=0 the next cycle, no cpu_rvalid, state is IDLE, and a new tie goes to cpu.
- Request withdrawn:
  - Stimulus: cpu_req drops in ACCESS.
  - Response: cpu_rvalid still pulses in RESP and cpu_stall=0 once req is low; a pending dbg request is served next.
- Strobe exclusivity:
  - Stimulus: random 1000-access mix on both ports.
  - Response: dm_R and dm_W are never 1 together and each strobe lasts exactly one cycle; checked against a scoreboard memory model.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types for the data-memory arbiter: FSM states, owner encoding, default depth.
package dm_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  typedef enum logic {
    OwnCpu = 1'b0,
    OwnDbg = 1'b1
  } owner_e;

  localparam int unsigned NumWordsDef = 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins; on a tie the one not served last wins.
module rr_arb2 (
  input  logic [1:0] req,   // bit 0 = cpu, bit 1 = dbg
  input  logic       last,  // 1 = dbg was served last
  output logic [1:0] gnt
);

  // One-hot grant; a tie goes to the requester that did not win last time
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Arbiter/sequencer in front of a combinational single-ported data memory.
// Each accepted request becomes one IDLE -> ACCESS -> RESP pass with a single R or W strobe.
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int unsigned NUM_WORDS = NumWordsDef,
  parameter int unsigned AW        = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [31:0]   cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [31:0]   dbg_wdata,
  output logic          dbg_rvalid,
  output logic [31:0]   dbg_rdata,
  output logic          dm_R,
  output logic          dm_W,
  output logic [AW-1:0] dm_Addr,
  output logic [31:0]   dm_W_data,
  input  logic [31:0]   dm_R_data,
  output logic          err
);

  state_e        state_q, state_d;
  owner_e        last_q, last_d;
  owner_e        owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [1:0]    gnt;
  logic          in_range;
  logic          in_access;
  logic          in_resp;

  // Full-width unsigned compare so huge addresses never alias into the array
  assign in_range = (addr_q < AW'(NUM_WORDS));

  rr_arb2 u_rr_arb2 (
    .req  ({dbg_req, cpu_req}),
    .last (last_q),
    .gnt  (gnt)
  );

  // State and latched-transaction registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      last_q  <= OwnDbg;
      owner_q <= OwnCpu;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state: accept in IDLE, capture read data at end of ACCESS, record owner in RESP
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (gnt != 2'b00) begin
          state_d = StAccess;
          if (gnt[1]) begin
            owner_d = OwnDbg;
            we_d    = dbg_we;
            addr_d  = dbg_addr;
            wdata_d = dbg_wdata;
          end else begin
            owner_d = OwnCpu;
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
          end
        end
      end
      StAccess: begin
        rdata_d = (~we_q & in_range) ? dm_R_data : 32'h0;
        state_d = StResp;
      end
      StResp: begin
        last_d  = owner_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state and latched registers only
  always_comb begin
    in_access  = (state_q == StAccess);
    in_resp    = (state_q == StResp);
    dm_R       = in_access & ~we_q & in_range;
    dm_W       = in_access & we_q & in_range;
    dm_Addr    = addr_q;
    dm_W_data  = wdata_q;
    cpu_rvalid = in_resp & (owner_q == OwnCpu);
    dbg_rvalid = in_resp & (owner_q == OwnDbg);
    cpu_rdata  = cpu_rvalid ? rdata_q : 32'h0;
    dbg_rdata  = dbg_rvalid ? rdata_q : 32'h0;
    err        = in_resp & ~in_range;
  end

  assign cpu_stall = cpu_req & ~cpu_rvalid;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios followed by a random two-port mix,
// all checked against a transaction-level reference model.
module tb_dm_arbiter;

  localparam int unsigned NW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic        cpu_stall, cpu_rvalid, dbg_rvalid, dm_R, dm_W, err;
  logic [31:0] cpu_rdata, dbg_rdata, dm_Addr, dm_W_data, dm_R_data;

  always #5 clk = ~clk;

  dm_arbiter #(.NUM_WORDS(NW), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .dm_R(dm_R), .dm_W(dm_W), .dm_Addr(dm_Addr), .dm_W_data(dm_W_data),
    .dm_R_data(dm_R_data), .err(err)
  );

  // Environment memory: combinational read, write on the strobe
  logic [31:0] env_mem [NW];
  assign dm_R_data = (dm_R && dm_Addr < NW) ? env_mem[dm_Addr[2:0]] : 32'hA5A5_5A5A;
  always @(posedge clk) if (dm_W && dm_Addr < NW) env_mem[dm_Addr[2:0]] <= dm_W_data;

  // Reference model state
  int          tests = 0, fails = 0, cyc = 0, rv_seen = 0, idle_at = 0, ts = -100;
  bit          chk_en = 0, rnd_en = 0, rst_drv = 1, last_dbg = 1;
  bit          rq_v [2], rq_we [2], hold [2], inflight [2];
  logic [31:0] rq_addr [2], rq_wd [2], got_rdata [2];
  logic [31:0] ref_mem [NW];
  bit          t_own, t_we, t_inr;
  logic [31:0] t_addr, t_wd, exp_addr = 0, exp_wd = 0;
  int          order_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s at cycle %0d: got %h want %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic set_rq(input int p, input bit we, input logic [31:0] a, input logic [31:0] d);
    rq_v[p] = 1; rq_we[p] = we; rq_addr[p] = a; rq_wd[p] = d;
  endtask

  function automatic logic [31:0] rnd_addr();
    int sel = $urandom_range(0, 7);
    if (sel == 0) return 32'd8;
    if (sel == 1) return $urandom | 32'h8000_0000;
    return 32'($urandom_range(0, NW - 1));
  endfunction

  // One clock: check cycle outputs, update requesters, drive inputs, then model sampling
  task automatic step();
    bit e_r, e_w, e_rv0, e_rv1, e_err, w;
    @(negedge clk);
    cyc++;
    e_r   = (cyc == ts + 1) && !t_we && t_inr;
    e_w   = (cyc == ts + 1) && t_we && t_inr;
    e_rv0 = (cyc == ts + 2) && !t_own;
    e_rv1 = (cyc == ts + 2) && t_own;
    e_err = (cyc == ts + 2) && !t_inr;
    if (chk_en) begin
      chk("dm_R", dm_R, e_r);
      chk("dm_W", dm_W, e_w);
      chk("strobe_excl", dm_R & dm_W, 0);
      chk("cpu_rvalid", cpu_rvalid, e_rv0);
      chk("dbg_rvalid", dbg_rvalid, e_rv1);
      chk("err", err, e_err);
      chk("dm_Addr", dm_Addr, exp_addr);
      chk("dm_W_data", dm_W_data, exp_wd);
      if (e_rv0 || e_rv1) begin
        if (!t_we) chk(t_own ? "dbg_rdata" : "cpu_rdata", t_own ? dbg_rdata : cpu_rdata,
                       t_inr ? ref_mem[t_addr[2:0]] : 32'h0);
        chk("nonowner_rdata", t_own ? cpu_rdata : dbg_rdata, 32'h0);
      end
    end
    if (cpu_rvalid) begin order_q.push_back(0); got_rdata[0] = cpu_rdata; rv_seen++; end
    if (dbg_rvalid) begin order_q.push_back(1); got_rdata[1] = dbg_rdata; rv_seen++; end
    if (e_w) ref_mem[t_addr[2:0]] = t_wd;
    if (cyc == ts + 2) begin
      last_dbg = t_own;
      inflight[t_own] = 0;
      if (!hold[t_own]) rq_v[t_own] = 0;
    end
    if (rnd_en) begin
      for (int p = 0; p < 2; p++) begin
        if (!rq_v[p] && !inflight[p] && $urandom_range(0, 1) == 1)
          set_rq(p, 1'($urandom_range(0, 1)), rnd_addr(), $urandom);
        else if (rq_v[p] && inflight[p] && $urandom_range(0, 7) == 0)
          rq_v[p] = 0;
      end
      rst_drv = ($urandom_range(0, 299) == 0);
    end
    rst = rst_drv;
    cpu_req = rq_v[0]; cpu_we = rq_we[0]; cpu_addr = rq_addr[0]; cpu_wdata = rq_wd[0];
    dbg_req = rq_v[1]; dbg_we = rq_we[1]; dbg_addr = rq_addr[1]; dbg_wdata = rq_wd[1];
    #1;
    if (chk_en) chk("cpu_stall", cpu_stall, rq_v[0] & !e_rv0);
    if (rst_drv) begin
      ts = -100; last_dbg = 1; idle_at = cyc + 1;
      inflight[0] = 0; inflight[1] = 0; exp_addr = 0; exp_wd = 0;
    end else if (cyc >= idle_at && (rq_v[0] || rq_v[1])) begin
      w = (rq_v[0] && rq_v[1]) ? !last_dbg : rq_v[1];
      ts = cyc; t_own = w; t_we = rq_we[w]; t_addr = rq_addr[w]; t_wd = rq_wd[w];
      t_inr = (t_addr < NW);
      inflight[w] = 1; idle_at = cyc + 3;
      exp_addr = t_addr; exp_wd = t_wd;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int target;
    for (int i = 0; i < int'(NW); i++) begin
      env_mem[i] = 32'h1000_0000 + 32'(i) * 32'h111;
      ref_mem[i] = 32'h1000_0000 + 32'(i) * 32'h111;
    end
    for (int p = 0; p < 2; p++) begin
      rq_v[p] = 0; rq_we[p] = 0; rq_addr[p] = 0; rq_wd[p] = 0; hold[p] = 0; inflight[p] = 0;
      got_rdata[p] = 0;
    end
    rst = 1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;

    // Reset, then check the idle reset state
    step(); step();
    rst_drv = 0; chk_en = 1;
    step(); step();

    // CPU write then read-back of address 3
    set_rq(0, 1, 32'd3, 32'hDEAD_BEEF);
    repeat (4) step();
    set_rq(0, 0, 32'd3, 32'h0);
    got_rdata[0] = 0;
    repeat (4) step();
    chk("wr_rd_back", got_rdata[0], 32'hDEAD_BEEF);

    // Tie right after reset: cpu, dbg, cpu
    rst_drv = 1; step(); rst_drv = 0;
    hold[0] = 1; hold[1] = 1;
    set_rq(0, 0, 32'd1, 32'h0);
    set_rq(1, 0, 32'd2, 32'h0);
    order_q.delete();
    repeat (9) step();
    hold[0] = 0; hold[1] = 0; rq_v[0] = 0; rq_v[1] = 0;
    chk("tie_count", order_q.size(), 3);
    if (order_q.size() == 3) begin
      chk("tie_first", order_q[0], 0);
      chk("tie_second", order_q[1], 1);
      chk("tie_third", order_q[2], 0);
    end
    repeat (2) step();

    // Out-of-range dbg read
    got_rdata[1] = 32'hFFFF_FFFF;
    set_rq(1, 0, 32'd8, 32'h0);
    repeat (4) step();
    chk("oor_rdata", got_rdata[1], 32'h0);

    // Reset during ACCESS of a cpu write; new tie goes to cpu
    set_rq(0, 1, 32'd5, 32'h1234_5678);
    step();
    rst_drv = 1; step(); rst_drv = 0;
    set_rq(1, 0, 32'd5, 32'h0);
    order_q.delete();
    repeat (6) step();
    chk("rst_tie_count", order_q.size(), 2);
    if (order_q.size() == 2) chk("rst_tie_first", order_q[0], 0);
    chk("rst_wr_landed", got_rdata[1], 32'h1234_5678);
    repeat (2) step();

    // CPU withdraws during ACCESS; pending dbg served next
    order_q.delete();
    set_rq(0, 0, 32'd3, 32'h0);
    step();
    rq_v[0] = 0;
    set_rq(1, 0, 32'd4, 32'h0);
    repeat (5) step();
    chk("wd_count", order_q.size(), 2);
    if (order_q.size() == 2) begin
      chk("wd_first", order_q[0], 0);
      chk("wd_second", order_q[1], 1);
    end
    repeat (2) step();

    // Random mix on both ports
    rnd_en = 1;
    target = rv_seen + 1000;
    for (int g = 0; g < 20000 && rv_seen < target; g++) step();
    chk("rnd_budget", 32'(rv_seen >= target), 1);
    rnd_en = 0; rst_drv = 0; rq_v[0] = 0; rq_v[1] = 0;
    repeat (6) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
